// File: rtl/mem_stream_pkg.sv
// Shared state encoding and width helpers for the memory stream reader.
package mem_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  // A one-word memory still needs a one-bit address bus.
  function automatic int addr_width(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

  function automatic int len_width(input int height);
    return (height > 0) ? $clog2(height + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_stream_reader_chk.sv
// Simulation-only protocol checks for the memory stream reader.
module mem_stream_reader_chk #(
  parameter int HEIGHT = 1,
  parameter int LW     = 1
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push,
  input logic          full,
  input logic          pop,
  input logic          accept,
  input logic [LW-1:0] length
);

`ifndef TARGET_SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) (push && full) |-> pop)
    else $error("push into a full FIFO without a pop");

  a_length_range: assert property (@(posedge clk) disable iff (!rst_n) accept |-> (length <= LW'(HEIGHT)))
    else $error("accepted length exceeds memory height");
`endif

endmodule

// File: rtl/stream_fifo.sv
// Small register FIFO; a full FIFO still accepts a push when it is popped in the same cycle.
module stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             pop_s;
  logic             push_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign empty  = (count_r == CW'(0));
  assign full   = (count_r == CW'(DEPTH));
  assign count  = count_r;
  assign head   = mem_r[rd_ptr_r];
  assign pop_s  = pop && !empty;
  assign push_s = push && (!full || pop_s);

  // Storage, pointers and occupancy; storage is cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CW'(1);
      end else if (!push_s && pop_s) begin
        count_r <= count_r - CW'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// Streams a wrap-around address range out of an attached memory through a small FIFO;
// read_en is raised only on cycles that actually fetch a word.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int HEIGHT     = 1,
  parameter int FIFO_DEPTH = 2,
  localparam int AW = addr_width(HEIGHT),
  localparam int LW = len_width(HEIGHT),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [LW-1:0]    length,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    read_addr,
  output logic             read_en,
  input  logic [WIDTH-1:0] qin,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e        state_r;
  logic [AW-1:0] addr_r;
  logic [LW-1:0] rem_r;
  logic          issue_s;
  logic          drained_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;

  assign out_valid = !empty_s;
  assign pop_s     = out_valid && out_ready;
  assign read_en   = issue_s;
  assign read_addr = addr_r;
  assign busy      = (state_r != IDLE);
  assign done      = (state_r == FINISH);

  // Fetch only while words remain and the FIFO has room, counting a same-cycle pop as room.
  always_comb begin
    issue_s = 1'b0;
    if ((state_r == RUN) && (rem_r != {LW{1'b0}}) && (!full_s || pop_s)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // FIFO ends this cycle empty.
  always_comb begin
    drained_s = 1'b0;
    if ((count_s == CW'(0)) || ((count_s == CW'(1)) && pop_s)) begin
      drained_s = 1'b1;
    end else begin
      drained_s = 1'b0;
    end
  end

  // Command FSM with address and remaining-word counters.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_r <= IDLE;
      addr_r  <= {AW{1'b0}};
      rem_r   <= {LW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (length != {LW{1'b0}}) begin
              addr_r  <= base_addr;
              rem_r   <= length;
              state_r <= RUN;
            end else begin
              state_r <= FINISH;
            end
          end
        end
        RUN: begin
          if (issue_s) begin
            addr_r <= (addr_r == AW'(HEIGHT - 1)) ? {AW{1'b0}} : addr_r + AW'(1);
            rem_r  <= rem_r - LW'(1);
            if (rem_r == LW'(1)) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drained_s) begin
            state_r <= FINISH;
          end
        end
        FINISH: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  stream_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (arst_n_in),
    .push     (issue_s),
    .push_data(qin),
    .pop      (pop_s),
    .head     (out_data),
    .full     (full_s),
    .empty    (empty_s),
    .count    (count_s)
  );

`ifndef TARGET_SYNTHESIS
  mem_stream_reader_chk #(
    .HEIGHT(HEIGHT),
    .LW    (LW)
  ) u_chk (
    .clk   (clk),
    .rst_n (arst_n_in),
    .push  (issue_s),
    .full  (full_s),
    .pop   (pop_s),
    .accept((state_r == IDLE) && start),
    .length(length)
  );
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader with a 16-word memory preloaded as data[i] = i + 100.
module tb_mem_stream_reader;

  logic        clk = 1'b0;
  logic        arst_n_in;
  logic        start;
  logic [3:0]  base_addr;
  logic [4:0]  length;
  logic        busy;
  logic        done;
  logic [3:0]  read_addr;
  logic        read_en;
  logic [15:0] qin;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic        busy_log  [64];
  logic        rd_log    [64];
  logic [3:0]  addr_log  [64];
  logic        valid_log [64];
  logic [15:0] data_log  [64];
  logic        ready_log [64];
  logic        done_log  [64];

  always #5 clk = ~clk;

  // Zero-latency memory model.
  assign qin = {12'd0, read_addr} + 16'd100;

  mem_stream_reader #(.WIDTH(16), .HEIGHT(16), .FIFO_DEPTH(2)) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .read_addr(read_addr), .read_en(read_en), .qin(qin),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Issues a start in the current cycle (offset 0) and logs outputs for ncyc cycles.
  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1 by offset.
  // rk >= 0 pulses a second start (base 9, length 3) at that offset.
  task automatic run_cmd(input logic [3:0] b, input logic [4:0] len, input int mode, input int rk, input int ncyc);
    start = 1'b1; base_addr = b; length = len;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) begin
        start = (k == rk);
        if (k == rk) begin base_addr = 4'd9; length = 5'd3; end
      end
      out_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      @(negedge clk);
      busy_log[k] = busy; rd_log[k] = read_en; addr_log[k] = read_addr;
      valid_log[k] = out_valid; data_log[k] = out_data; ready_log[k] = out_ready; done_log[k] = done;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_checks++; if (read_en !== 1'b0) begin n_fail++; $display("FAIL reset_read_en got %0b want 0", read_en); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_checks++; if (read_addr !== 4'd0) begin n_fail++; $display("FAIL reset_read_addr got %0d want 0", read_addr); end
    n_checks++; if (out_data !== 16'd0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", out_data); end
  endtask

  task automatic test_basic;
    logic ex_rd, ex_v;
    run_cmd(4'd0, 5'd4, 0, -1, 10);
    for (int k = 0; k < 10; k++) begin
      ex_rd = (k >= 1) && (k <= 4);
      ex_v  = (k >= 2) && (k <= 5);
      n_checks++; if (rd_log[k] !== ex_rd) begin n_fail++; $display("FAIL basic_read_en k=%0d got %0b want %0b", k, rd_log[k], ex_rd); end
      if (ex_rd) begin
        n_checks++; if (addr_log[k] !== 4'(k - 1)) begin n_fail++; $display("FAIL basic_addr k=%0d got %0d want %0d", k, addr_log[k], k - 1); end
      end
      n_checks++; if (valid_log[k] !== ex_v) begin n_fail++; $display("FAIL basic_valid k=%0d got %0b want %0b", k, valid_log[k], ex_v); end
      if (ex_v) begin
        n_checks++; if (data_log[k] !== 16'(100 + k - 2)) begin n_fail++; $display("FAIL basic_data k=%0d got %0d want %0d", k, data_log[k], 100 + k - 2); end
      end
      n_checks++; if (done_log[k] !== (k == 6)) begin n_fail++; $display("FAIL basic_done k=%0d got %0b", k, done_log[k]); end
      n_checks++; if (busy_log[k] !== ((k >= 1) && (k <= 6))) begin n_fail++; $display("FAIL basic_busy k=%0d got %0b", k, busy_log[k]); end
    end
  endtask

  // Wrapping range, with a start pulse during RUN that must be ignored.
  task automatic test_wrap_ignore;
    logic ex_rd, ex_v;
    run_cmd(4'd14, 5'd4, 0, 2, 12);
    for (int k = 0; k < 12; k++) begin
      ex_rd = (k >= 1) && (k <= 4);
      ex_v  = (k >= 2) && (k <= 5);
      n_checks++; if (rd_log[k] !== ex_rd) begin n_fail++; $display("FAIL wrap_read_en k=%0d got %0b want %0b", k, rd_log[k], ex_rd); end
      if (ex_rd) begin
        n_checks++; if (addr_log[k] !== 4'((14 + k - 1) % 16)) begin n_fail++; $display("FAIL wrap_addr k=%0d got %0d want %0d", k, addr_log[k], (14 + k - 1) % 16); end
      end
      n_checks++; if (valid_log[k] !== ex_v) begin n_fail++; $display("FAIL wrap_valid k=%0d got %0b want %0b", k, valid_log[k], ex_v); end
      if (ex_v) begin
        n_checks++; if (data_log[k] !== 16'(100 + (14 + k - 2) % 16)) begin n_fail++; $display("FAIL wrap_data k=%0d got %0d want %0d", k, data_log[k], 100 + (14 + k - 2) % 16); end
      end
      n_checks++; if (done_log[k] !== (k == 6)) begin n_fail++; $display("FAIL wrap_done k=%0d got %0b", k, done_log[k]); end
    end
  endtask

  task automatic test_backpressure;
    int cnt, rem, popped, reads, done_k, dut_reads;
    logic ex_v, ex_rd, pop;
    cnt = 0; rem = 6; popped = 0; reads = 0; done_k = -1; dut_reads = 0;
    run_cmd(4'd3, 5'd6, 1, -1, 20);
    n_checks++; if (rd_log[0] !== 1'b0) begin n_fail++; $display("FAIL bp_read_en_idle got %0b want 0", rd_log[0]); end
    for (int k = 1; k < 20; k++) begin
      ex_v  = (cnt > 0);
      pop   = ex_v && ready_log[k];
      ex_rd = (rem > 0) && ((cnt < 2) || pop);
      n_checks++; if (valid_log[k] !== ex_v) begin n_fail++; $display("FAIL bp_valid k=%0d got %0b want %0b", k, valid_log[k], ex_v); end
      if (ex_v) begin
        n_checks++; if (data_log[k] !== 16'(103 + popped)) begin n_fail++; $display("FAIL bp_data k=%0d got %0d want %0d", k, data_log[k], 103 + popped); end
      end
      n_checks++; if (rd_log[k] !== ex_rd) begin n_fail++; $display("FAIL bp_read_en k=%0d got %0b want %0b", k, rd_log[k], ex_rd); end
      if (ex_rd) begin
        n_checks++; if (addr_log[k] !== 4'(3 + reads)) begin n_fail++; $display("FAIL bp_addr k=%0d got %0d want %0d", k, addr_log[k], 3 + reads); end
      end
      n_checks++; if (done_log[k] !== (k == done_k)) begin n_fail++; $display("FAIL bp_done k=%0d got %0b", k, done_log[k]); end
      if (rd_log[k] === 1'b1) dut_reads++;
      if (pop) popped++;
      if (ex_rd) begin reads++; rem--; end
      cnt = cnt + (ex_rd ? 1 : 0) - (pop ? 1 : 0);
      if (pop && popped == 6) done_k = k + 1;
    end
    n_checks++; if (dut_reads !== 6) begin n_fail++; $display("FAIL bp_read_count got %0d want 6", dut_reads); end
  endtask

  // Zero length, plus a start while in FINISH that must be ignored.
  task automatic test_zero_length;
    run_cmd(4'd0, 5'd0, 0, 1, 6);
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (rd_log[k] !== 1'b0) begin n_fail++; $display("FAIL zero_read_en k=%0d got %0b want 0", k, rd_log[k]); end
      n_checks++; if (busy_log[k] !== (k == 1)) begin n_fail++; $display("FAIL zero_busy k=%0d got %0b", k, busy_log[k]); end
      n_checks++; if (done_log[k] !== (k == 1)) begin n_fail++; $display("FAIL zero_done k=%0d got %0b", k, done_log[k]); end
    end
  endtask

  task automatic test_full_range;
    logic ex_rd, ex_v;
    run_cmd(4'd5, 5'd16, 0, -1, 22);
    for (int k = 0; k < 22; k++) begin
      ex_rd = (k >= 1) && (k <= 16);
      ex_v  = (k >= 2) && (k <= 17);
      n_checks++; if (rd_log[k] !== ex_rd) begin n_fail++; $display("FAIL full_read_en k=%0d got %0b want %0b", k, rd_log[k], ex_rd); end
      if (ex_rd) begin
        n_checks++; if (addr_log[k] !== 4'((5 + k - 1) % 16)) begin n_fail++; $display("FAIL full_addr k=%0d got %0d want %0d", k, addr_log[k], (5 + k - 1) % 16); end
      end
      if (ex_v) begin
        n_checks++; if (data_log[k] !== 16'(100 + (5 + k - 2) % 16)) begin n_fail++; $display("FAIL full_data k=%0d got %0d want %0d", k, data_log[k], 100 + (5 + k - 2) % 16); end
      end
      n_checks++; if (done_log[k] !== (k == 18)) begin n_fail++; $display("FAIL full_done k=%0d got %0b", k, done_log[k]); end
    end
  endtask

  task automatic test_reset_mid;
    logic saw_done;
    start = 1'b1; base_addr = 4'd0; length = 5'd8; out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (out_data !== 16'd102) begin n_fail++; $display("FAIL rst_mid_third_word got %0d want 102", out_data); end
    arst_n_in = 1'b0; #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %0b want 0", busy); end
    n_checks++; if (read_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_read_en got %0b want 0", read_en); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %0b want 0", out_valid); end
    n_checks++; if (read_addr !== 4'd0) begin n_fail++; $display("FAIL rst_mid_addr got %0d want 0", read_addr); end
    n_checks++; if (out_data !== 16'd0) begin n_fail++; $display("FAIL rst_mid_data got %0d want 0", out_data); end
    saw_done = 1'b0;
    repeat (3) begin @(negedge clk); if (done !== 1'b0) saw_done = 1'b1; end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %0b want 0", saw_done); end
    @(posedge clk); #1; arst_n_in = 1'b1;
    @(posedge clk); #1;
    run_cmd(4'd2, 5'd2, 0, -1, 8);
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (rd_log[k] !== ((k >= 1) && (k <= 2))) begin n_fail++; $display("FAIL rst_after_read_en k=%0d got %0b", k, rd_log[k]); end
      if ((k >= 1) && (k <= 2)) begin
        n_checks++; if (addr_log[k] !== 4'(2 + k - 1)) begin n_fail++; $display("FAIL rst_after_addr k=%0d got %0d want %0d", k, addr_log[k], 2 + k - 1); end
      end
      n_checks++; if (valid_log[k] !== ((k >= 2) && (k <= 3))) begin n_fail++; $display("FAIL rst_after_valid k=%0d got %0b", k, valid_log[k]); end
      if ((k >= 2) && (k <= 3)) begin
        n_checks++; if (data_log[k] !== 16'(102 + k - 2)) begin n_fail++; $display("FAIL rst_after_data k=%0d got %0d want %0d", k, data_log[k], 102 + k - 2); end
      end
      n_checks++; if (done_log[k] !== (k == 4)) begin n_fail++; $display("FAIL rst_after_done k=%0d got %0b", k, done_log[k]); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n_in = 1'b0; start = 1'b0; base_addr = 4'd0; length = 5'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    @(posedge clk); #1; arst_n_in = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_wrap_ignore();
    test_backpressure();
    test_zero_length();
    test_full_range();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
